// File: rtl/level_ctrl.sv
// Game speed level controller: rally hits step the level up, a miss steps it down and opens a penalty window.
// Manual up/down buttons are synchronized and edge-detected; all outputs are registered one cycle after the event.
module level_ctrl #(
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned PENALTY_CYC    = 8,
    parameter logic [1:0]  START_LEVEL    = 2'b00
) (
    input  logic       clk_lf,
    input  logic       btnC_n,
    input  logic       hit,
    input  logic       miss,
    input  logic       btnU,
    input  logic       btnD,
    output logic [1:0] level,
    output logic [3:0] hit_cnt,
    output logic       lvl_up,
    output logic       lvl_dn,
    output logic       penalty
);

    localparam logic [0:0] ST_RALLY   = 1'b0;
    localparam logic [0:0] ST_PENALTY = 1'b1;
    localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
    localparam logic [7:0] PEN_LOAD   = 8'(PENALTY_CYC - 1);

    logic       up_s1_q, up_s2_q, up_s3_q;
    logic       up_s1_d, up_s2_d, up_s3_d;
    logic       dn_s1_q, dn_s2_q, dn_s3_q;
    logic       dn_s1_d, dn_s2_d, dn_s3_d;
    logic       up_evt, dn_evt;

    logic [0:0] state_q, state_d;
    logic [7:0] pen_cnt_q, pen_cnt_d;
    logic [1:0] level_q, level_d;
    logic [3:0] hit_cnt_q, hit_cnt_d;
    logic       lvl_up_q, lvl_up_d;
    logic       lvl_dn_q, lvl_dn_d;

    always_comb begin
        // s1/s2 form the synchronizer, s3 holds the previous synchronized value for edge detection
        up_s1_d = btnU;
        up_s2_d = up_s1_q;
        up_s3_d = up_s2_q;
        dn_s1_d = btnD;
        dn_s2_d = dn_s1_q;
        dn_s3_d = dn_s2_q;
        up_evt  = up_s2_q & ~up_s3_q;
        dn_evt  = dn_s2_q & ~dn_s3_q;
    end

    always_comb begin
        state_d   = state_q;
        pen_cnt_d = pen_cnt_q;
        level_d   = level_q;
        hit_cnt_d = hit_cnt_q;
        lvl_up_d  = 1'b0;
        lvl_dn_d  = 1'b0;

        // The penalty window runs down independently of manual level changes.
        if (state_q == ST_PENALTY) begin
            if (pen_cnt_q == 8'd0) begin
                state_d = ST_RALLY;
            end else begin
                pen_cnt_d = pen_cnt_q - 8'd1;
            end
        end

        if (miss) begin
            hit_cnt_d = 4'd0;
            state_d   = ST_PENALTY;
            pen_cnt_d = PEN_LOAD;
            if (level_q != 2'b00) begin
                level_d  = level_q - 2'd1;
                lvl_dn_d = 1'b1;
            end
        end else if (up_evt) begin
            hit_cnt_d = 4'd0;
            if (level_q != 2'b11) begin
                level_d  = level_q + 2'd1;
                lvl_up_d = 1'b1;
            end
        end else if (dn_evt) begin
            hit_cnt_d = 4'd0;
            if (level_q != 2'b00) begin
                level_d  = level_q - 2'd1;
                lvl_dn_d = 1'b1;
            end
        end else if (hit && (state_q == ST_RALLY)) begin
            if (hit_cnt_q == HIT_LAST) begin
                // At top speed the count parks at the last value instead of wrapping.
                if (level_q != 2'b11) begin
                    level_d   = level_q + 2'd1;
                    hit_cnt_d = 4'd0;
                    lvl_up_d  = 1'b1;
                end
            end else begin
                hit_cnt_d = hit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_lf or negedge btnC_n) begin
        if (!btnC_n) begin
            up_s1_q   <= 1'b0;
            up_s2_q   <= 1'b0;
            up_s3_q   <= 1'b0;
            dn_s1_q   <= 1'b0;
            dn_s2_q   <= 1'b0;
            dn_s3_q   <= 1'b0;
            state_q   <= ST_RALLY;
            pen_cnt_q <= 8'd0;
            level_q   <= START_LEVEL;
            hit_cnt_q <= 4'd0;
            lvl_up_q  <= 1'b0;
            lvl_dn_q  <= 1'b0;
        end else begin
            up_s1_q   <= up_s1_d;
            up_s2_q   <= up_s2_d;
            up_s3_q   <= up_s3_d;
            dn_s1_q   <= dn_s1_d;
            dn_s2_q   <= dn_s2_d;
            dn_s3_q   <= dn_s3_d;
            state_q   <= state_d;
            pen_cnt_q <= pen_cnt_d;
            level_q   <= level_d;
            hit_cnt_q <= hit_cnt_d;
            lvl_up_q  <= lvl_up_d;
            lvl_dn_q  <= lvl_dn_d;
        end
    end

    assign level   = level_q;
    assign hit_cnt = hit_cnt_q;
    assign lvl_up  = lvl_up_q;
    assign lvl_dn  = lvl_dn_q;
    assign penalty = (state_q == ST_PENALTY);

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl: cycle table for hit/miss/penalty behaviour, hand sequences for buttons and async reset.
module tb_level_ctrl;

    logic       clk_lf = 1'b0;
    logic       btnC_n, hit, miss, btnU, btnD;
    logic [1:0] level;
    logic [3:0] hit_cnt;
    logic       lvl_up, lvl_dn, penalty;
    logic [8:0] obs;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       hit;
        logic       miss;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_lf = ~clk_lf;

    level_ctrl #(
        .HITS_PER_LEVEL(4),
        .PENALTY_CYC   (8),
        .START_LEVEL   (2'b00)
    ) dut (
        .clk_lf (clk_lf),
        .btnC_n (btnC_n),
        .hit    (hit),
        .miss   (miss),
        .btnU   (btnU),
        .btnD   (btnD),
        .level  (level),
        .hit_cnt(hit_cnt),
        .lvl_up (lvl_up),
        .lvl_dn (lvl_dn),
        .penalty(penalty)
    );

    assign obs = {level, hit_cnt, lvl_up, lvl_dn, penalty};

    function automatic logic [8:0] pk(input logic [1:0] l, input logic [3:0] c,
                                      input logic u, input logic d, input logic p);
        return {l, c, u, d, p};
    endfunction

    function automatic void add(input logic h, input logic m, input logic [1:0] l,
                                input logic [3:0] c, input logic u, input logic d, input logic p);
        vec_t v;
        v.hit  = h;
        v.miss = m;
        v.exp  = pk(l, c, u, d, p);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got level=%0d hit_cnt=%0d up=%0b dn=%0b pen=%0b, want level=%0d hit_cnt=%0d up=%0b dn=%0b pen=%0b",
                     name, obs[8:7], obs[6:3], obs[2], obs[1], obs[0],
                     exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk_lf);
        #1;
    endtask

    initial begin
        // Four spaced hits from level 0: count 1,2,3 then step up.
        for (int k = 0; k < 4; k++) begin
            add(1'b1, 1'b0, (k == 3) ? 2'd1 : 2'd0, (k == 3) ? 4'd0 : 4'(k + 1), k == 3, 1'b0, 1'b0);
            add(1'b0, 1'b0, (k == 3) ? 2'd1 : 2'd0, (k == 3) ? 4'd0 : 4'(k + 1), 1'b0, 1'b0, 1'b0);
        end
        // Back-to-back hits up to the top level.
        for (int lv = 1; lv < 3; lv++) begin
            for (int k = 0; k < 4; k++) begin
                add(1'b1, 1'b0, (k == 3) ? 2'(lv + 1) : 2'(lv), (k == 3) ? 4'd0 : 4'(k + 1),
                    k == 3, 1'b0, 1'b0);
            end
        end
        // Ten hits at top speed: count saturates at 3, no up pulse.
        for (int k = 0; k < 10; k++) begin
            add(1'b1, 1'b0, 2'd3, (k < 3) ? 4'(k + 1) : 4'd3, 1'b0, 1'b0, 1'b0);
        end
        // Miss, then hits through the 8-cycle window are ignored.
        add(1'b0, 1'b1, 2'd2, 4'd0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) add(1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0);
        // Miss at level 2 with hit_cnt 2.
        add(1'b0, 1'b1, 2'd1, 4'd0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) add(1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        // hit+miss together: miss wins. Then a second miss at 0 restarts the window.
        add(1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) add(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        btnC_n = 1'b0;
        hit    = 1'b0;
        miss   = 1'b0;
        btnU   = 1'b0;
        btnD   = 1'b0;
        #12;
        check("reset", pk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        btnC_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            hit  = vecs[i].hit;
            miss = vecs[i].miss;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        hit  = 1'b0;
        miss = 1'b0;

        // Held up button: one event, visible on the third edge.
        btnU = 1'b1;
        step();
        check("up_e1", pk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        step();
        check("up_e2", pk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        step();
        check("up_e3", pk(2'd1, 4'd0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 17; k++) begin
            step();
            check($sformatf("up_hold%0d", k), pk(2'd1, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        btnU = 1'b0;
        repeat (3) step();

        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit_pre_btn", pk(2'd1, 4'd1, 1'b0, 1'b0, 1'b0));

        // Up and down rising together: up wins and clears the count.
        btnU = 1'b1;
        btnD = 1'b1;
        step();
        step();
        check("updn_e2", pk(2'd1, 4'd1, 1'b0, 1'b0, 1'b0));
        step();
        check("updn_win", pk(2'd2, 4'd0, 1'b1, 1'b0, 1'b0));
        step();
        check("updn_after", pk(2'd2, 4'd0, 1'b0, 1'b0, 1'b0));
        btnU = 1'b0;
        btnD = 1'b0;
        repeat (3) step();

        btnD = 1'b1;
        repeat (3) step();
        check("dn_only", pk(2'd1, 4'd0, 1'b0, 1'b1, 1'b0));
        btnD = 1'b0;
        repeat (3) step();

        btnU = 1'b1;
        repeat (3) step();
        check("up_to2", pk(2'd2, 4'd0, 1'b1, 1'b0, 1'b0));
        btnU = 1'b0;
        repeat (3) step();

        // Async reset in the middle of a penalty window, between edges.
        miss = 1'b1;
        step();
        miss = 1'b0;
        check("miss_pre_rst", pk(2'd1, 4'd0, 1'b0, 1'b1, 1'b1));
        step();
        step();
        check("pen_pre_rst", pk(2'd1, 4'd0, 1'b0, 1'b0, 1'b1));
        #3;
        btnC_n = 1'b0;
        #1;
        check("async_rst", pk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        #2;
        btnC_n = 1'b1;
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("post_rst_hit", pk(2'd0, 4'd1, 1'b0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
